// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized ring_clk rising edges over a
// GATE_CYCLES window. Define RING_FREQ_MINMAX_EN to add min_count/max_count tracking.
module ring_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ring_clk,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
`ifdef RING_FREQ_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_count,
    output logic [CNT_W-1:0] max_count
`endif
);

    // state   | meaning
    // IDLE    | waiting for start, ring oscillator off
    // SETTLE  | ring on, flushing synchronizer and history, no counting
    // MEASURE | counting detected rising edges for GATE_CYCLES cycles
    // REPORT  | publish count/overflow, pulse done on exit
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

    localparam int TMR_MAX = (GATE_CYCLES > SYNC_STAGES) ? GATE_CYCLES : SYNC_STAGES + 1;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SYNC_STAGES);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   ring_en_q, ring_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
`ifdef RING_FREQ_MINMAX_EN
    logic [CNT_W-1:0]       min_q, min_d;
    logic [CNT_W-1:0]       max_q, max_d;
`endif
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], ring_clk};
        hist_d     = sync_q[SYNC_STAGES-1];
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        ring_en_d  = ring_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef RING_FREQ_MINMAX_EN
        min_d      = min_q;
        max_d      = max_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETTLE;
                    timer_d   = SETTLE_LOAD;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    ring_en_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = MEASURE;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + 1'b1;
                end
                if (timer_q == '0) begin
                    state_d   = REPORT;
                    ring_en_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            REPORT: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                count_d    = cnt_q;
                overflow_d = ovf_q;
`ifdef RING_FREQ_MINMAX_EN
                // Reset values make the first report load both extremes naturally.
                if (cnt_q < min_q) min_d = cnt_q;
                if (cnt_q > max_q) max_d = cnt_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ring_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef RING_FREQ_MINMAX_EN
            min_q      <= '1;
            max_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            ring_en_q  <= ring_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef RING_FREQ_MINMAX_EN
            min_q      <= min_d;
            max_q      <= max_d;
`endif
        end
    end

    assign ring_en  = ring_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;
`ifdef RING_FREQ_MINMAX_EN
    assign min_count = min_q;
    assign max_count = max_q;
`endif

endmodule
